// File: rtl/dbg_mem_master.sv
// Debug-side memory master: sequences addr/din/we/clk_ld toward the CPU memory
// debug port for single or burst reads and writes, returning read words on a stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a command; cmd_ready high
// RD_SETTLE | addr driven, counting SETTLE cycles before sampling dout_*
// RD_OUT    | rd_valid high, holding rd_data until rd_ready
// WR_WAIT   | wr_ready high, waiting for the next write word
// WR_CLK    | din/we set up one cycle ahead of the clk_ld rise
// WR_HOLD   | drop clk_ld, then hold we/addr/din one more cycle before advancing
module dbg_mem_master #(
   parameter int SETTLE = 1,
   parameter int LEN_W  = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [1:0]       cmd_sel,
   input  logic [31:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [31:0]      wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [31:0]      rd_data,
   output logic             busy,
   output logic             err,
   output logic [31:0]      addr,
   output logic [31:0]      din,
   output logic             we_dm,
   output logic             we_im,
   output logic             clk_ld,
   input  logic [31:0]      dout_dm,
   input  logic [31:0]      dout_im,
   input  logic [31:0]      dout_rf
);
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

   typedef enum logic [2:0] {
      IDLE, RD_SETTLE, RD_OUT, WR_WAIT, WR_CLK, WR_HOLD
   } state_t;

   state_t           state;
   logic [1:0]       sel_q;
   logic [LEN_W-1:0] remaining;
   logic [CNT_W-1:0] settle_cnt;
   logic [31:0]      dout_sel;
   logic             last_word;
   logic             cmd_bad;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign wr_ready  = (state == WR_WAIT);
   assign last_word = (remaining == LEN_W'(1));
   assign cmd_bad   = (cmd_len == '0) || (cmd_sel == 2'd3) ||
                      (cmd_write && (cmd_sel == 2'd2));

   always_comb begin
      case (sel_q)
         2'd0:    dout_sel = dout_dm;
         2'd1:    dout_sel = dout_im;
         default: dout_sel = dout_rf;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         sel_q      <= 2'd0;
         remaining  <= '0;
         settle_cnt <= '0;
         addr       <= 32'd0;
         din        <= 32'd0;
         we_dm      <= 1'b0;
         we_im      <= 1'b0;
         clk_ld     <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= 32'd0;
         err        <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_bad) begin
                     err <= 1'b1;
                  end else begin
                     sel_q      <= cmd_sel;
                     remaining  <= cmd_len;
                     addr       <= cmd_addr;
                     settle_cnt <= SETTLE_LOAD;
                     state      <= cmd_write ? WR_WAIT : RD_SETTLE;
                  end
               end
            end
            RD_SETTLE: begin
               if (settle_cnt == '0) begin
                  rd_data  <= dout_sel;
                  rd_valid <= 1'b1;
                  state    <= RD_OUT;
               end else begin
                  settle_cnt <= settle_cnt - CNT_W'(1);
               end
            end
            RD_OUT: begin
               if (rd_ready) begin
                  rd_valid <= 1'b0;
                  if (last_word) begin
                     state <= IDLE;
                  end else begin
                     addr       <= addr + 32'd1;
                     remaining  <= remaining - LEN_W'(1);
                     settle_cnt <= SETTLE_LOAD;
                     state      <= RD_SETTLE;
                  end
               end
            end
            WR_WAIT: begin
               if (wr_valid) begin
                  din   <= wr_data;
                  we_dm <= (sel_q == 2'd0);
                  we_im <= (sel_q == 2'd1);
                  state <= WR_CLK;
               end
            end
            WR_CLK: begin
               clk_ld <= 1'b1;
               state  <= WR_HOLD;
            end
            WR_HOLD: begin
               // first cycle drops clk_ld, second releases we and advances
               if (clk_ld) begin
                  clk_ld <= 1'b0;
               end else begin
                  we_dm <= 1'b0;
                  we_im <= 1'b0;
                  if (last_word) begin
                     state <= IDLE;
                  end else begin
                     addr      <= addr + 32'd1;
                     remaining <= remaining - LEN_W'(1);
                     state     <= WR_WAIT;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dbg_mem_master.sv
// Self-checking bench for dbg_mem_master: vector table of single commands plus
// hand-written burst, write, reset and stream-isolation sequences.
module tb_dbg_mem_master;
   localparam int SETTLE = 1;
   localparam int LEN_W  = 16;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_write = 1'b0;
   logic [1:0]       cmd_sel = 2'd0;
   logic [31:0]      cmd_addr = 32'd0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic             wr_valid = 1'b0;
   logic             wr_ready;
   logic [31:0]      wr_data = 32'd0;
   logic             rd_valid;
   logic             rd_ready = 1'b1;
   logic [31:0]      rd_data;
   logic             busy;
   logic             err;
   logic [31:0]      addr;
   logic [31:0]      din;
   logic             we_dm;
   logic             we_im;
   logic             clk_ld;
   logic [31:0]      dout_dm;
   logic [31:0]      dout_im;
   logic [31:0]      dout_rf;

   dbg_mem_master #(.SETTLE(SETTLE), .LEN_W(LEN_W)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .busy(busy), .err(err), .addr(addr), .din(din),
      .we_dm(we_dm), .we_im(we_im), .clk_ld(clk_ld),
      .dout_dm(dout_dm), .dout_im(dout_im), .dout_rf(dout_rf)
   );

   always #5 clk = ~clk;

   // CPU-side memory contents as simple functions of the address
   assign dout_dm = (addr == 32'd5) ? 32'hDEADBEEF : (addr ^ 32'hA5A5_0000);
   assign dout_im = addr + 32'h1000_0000;
   assign dout_rf = {addr[15:0], 16'hF00D};

   int errors = 0;
   int checks = 0;
   int hs_count = 0;
   int ld_pulses = 0;
   logic we_im_seen = 1'b0;
   logic [31:0] last_addr = 32'd0;

   always @(posedge clk) begin
      if (rd_valid && rd_ready) hs_count++;
      if (we_im) we_im_seen = 1'b1;
   end
   always @(posedge clk_ld) ld_pulses++;

   typedef struct {
      logic        w;
      logic [1:0]  sel;
      logic [31:0] a;
      logic [15:0] len;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic w, input logic [1:0] sel, input logic [31:0] a,
                           input logic [15:0] len);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_sel   = sel;
      cmd_addr  = a;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic do_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      rd_ready = 1'b1;
      send_cmd(v.w, v.sel, v.a, v.len);
      if (v.exp_err) begin
         check({tag, "_err"}, {31'd0, err}, 32'd1);
         check({tag, "_busy"}, {31'd0, busy}, 32'd0);
         check({tag, "_noact"}, {29'd0, we_dm, we_im, clk_ld}, 32'd0);
         check({tag, "_addr_kept"}, addr, last_addr);
         tick();
         check({tag, "_err_pulse"}, {31'd0, err}, 32'd0);
      end else begin
         check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         check({tag, "_addr"}, addr, v.a);
         repeat (SETTLE) tick();
         check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd1);
         check({tag, "_rd_data"}, rd_data, v.exp_data);
         tick();
         check({tag, "_done"}, {30'd0, rd_valid, busy}, 32'd0);
         last_addr = v.a;
      end
   endtask

   task automatic write_word(input logic [31:0] data, input logic [31:0] a, input logic last);
      wr_valid = 1'b1;
      wr_data  = data;
      tick();
      wr_valid = 1'b0;
      check("wr_w0_din", din, data);
      check("wr_w0_we_ld", {30'd0, we_dm, clk_ld}, 32'd2);
      check("wr_w0_addr", addr, a);
      tick();
      check("wr_w1_we_ld", {30'd0, we_dm, clk_ld}, 32'd3);
      tick();
      check("wr_w2_we_ld", {30'd0, we_dm, clk_ld}, 32'd2);
      check("wr_w2_din", din, data);
      tick();
      check("wr_w3_we", {31'd0, we_dm}, 32'd0);
      check("wr_w3_addr", addr, last ? a : a + 32'd1);
      check("wr_w3_busy", {31'd0, busy}, last ? 32'd0 : 32'd1);
   endtask

   initial begin
      vecs[0] = '{1'b0, 2'd0, 32'h0000_0005, 16'd1, 1'b0, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 2'd0, 32'h0000_0100, 16'd1, 1'b0, 32'hA5A5_0100};
      vecs[2] = '{1'b0, 2'd1, 32'h0000_0020, 16'd1, 1'b0, 32'h1000_0020};
      vecs[3] = '{1'b0, 2'd2, 32'h0000_0003, 16'd1, 1'b0, 32'h0003_F00D};
      vecs[4] = '{1'b0, 2'd1, 32'hFFFF_FFFF, 16'd1, 1'b0, 32'h0FFF_FFFF};
      vecs[5] = '{1'b1, 2'd2, 32'h0000_0050, 16'd1, 1'b1, 32'h0};
      vecs[6] = '{1'b0, 2'd3, 32'h0000_0060, 16'd1, 1'b1, 32'h0};
      vecs[7] = '{1'b0, 2'd0, 32'h0000_0070, 16'd0, 1'b1, 32'h0};
      vecs[8] = '{1'b1, 2'd3, 32'h0000_0080, 16'd2, 1'b1, 32'h0};

      // reset state
      #2;
      check("rst_addr", addr, 32'd0);
      check("rst_din", din, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_flags", {26'd0, we_dm, we_im, clk_ld, rd_valid, err, busy}, 32'd0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      #10;
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) do_vec(vecs[i], i);
      check("rej_no_ld", ld_pulses, 0);

      // IM burst across 0x3FF/0x400 with a 3-cycle stall on the second word
      hs_count = 0;
      rd_ready = 1'b1;
      send_cmd(1'b0, 2'd1, 32'h0000_03FE, 16'd4);
      for (int k = 0; k < 4; k++) begin
         int n;
         n = 0;
         while (!rd_valid && n < 20) begin
            tick();
            n++;
         end
         check($sformatf("burst_w%0d_valid", k), {31'd0, rd_valid}, 32'd1);
         check($sformatf("burst_w%0d_addr", k), addr, 32'h0000_03FE + k);
         check($sformatf("burst_w%0d_data", k), rd_data, 32'h1000_03FE + k);
         if (k == 1) begin
            rd_ready = 1'b0;
            repeat (3) begin
               tick();
               check("burst_stall_valid", {31'd0, rd_valid}, 32'd1);
               check("burst_stall_data", rd_data, 32'h1000_03FF);
            end
            rd_ready = 1'b1;
         end
         tick();
      end
      check("burst_busy_end", {31'd0, busy}, 32'd0);
      check("burst_handshakes", hs_count, 4);
      check("burst_rd_data_kept", rd_data, 32'h1000_0401);

      // DM write, two words
      ld_pulses = 0;
      we_im_seen = 1'b0;
      send_cmd(1'b1, 2'd0, 32'h0000_0010, 16'd2);
      check("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
      check("wr_idle_we", {30'd0, we_dm, clk_ld}, 32'd0);
      write_word(32'h0000_0011, 32'h0000_0010, 1'b0);
      tick();
      check("wr_gap_noact", {30'd0, we_dm, clk_ld}, 32'd0);
      check("wr_gap_ready", {31'd0, wr_ready}, 32'd1);
      write_word(32'h0000_0022, 32'h0000_0011, 1'b1);
      check("wr_ld_pulses", ld_pulses, 2);
      check("wr_we_im_quiet", {31'd0, we_im_seen}, 32'd0);

      // RF read with wr_valid toggling: write stream must stay closed
      begin
         int n;
         int got;
         logic wr_ready_seen;
         got = 0;
         n = 0;
         wr_ready_seen = 1'b0;
         rd_ready = 1'b1;
         send_cmd(1'b0, 2'd2, 32'h0000_0003, 16'd2);
         while (busy && n < 30) begin
            wr_valid = ~wr_valid;
            wr_data  = $urandom;
            if (wr_ready) wr_ready_seen = 1'b1;
            if (rd_valid) begin
               check("rf_data", rd_data, 32'h0003_F00D + (got << 16));
               got++;
            end
            tick();
            n++;
         end
         wr_valid = 1'b0;
         check("rf_words", got, 2);
         check("rf_wr_ready_low", {31'd0, wr_ready_seen}, 32'd0);
         check("rf_no_write", {29'd0, we_dm, we_im, clk_ld}, 32'd0);
         check("rf_idle", {31'd0, busy}, 32'd0);
      end

      // async reset in the cycle after clk_ld rises
      send_cmd(1'b1, 2'd1, 32'h0000_0040, 16'd3);
      wr_valid = 1'b1;
      wr_data  = 32'h0000_0055;
      tick();
      wr_valid = 1'b0;
      tick();
      check("rst_mid_ld_high", {30'd0, we_im, clk_ld}, 32'd3);
      #2;
      rstn = 1'b0;
      #1;
      check("rst_mid_ld_we", {29'd0, we_dm, we_im, clk_ld}, 32'd0);
      check("rst_mid_addr", addr, 32'd0);
      check("rst_mid_ready", {30'd0, cmd_ready, busy}, 32'd2);
      #3;
      rstn = 1'b1;
      tick();
      check("rst_rel_ready", {31'd0, cmd_ready}, 32'd1);
      last_addr = 32'd0;
      do_vec(vecs[0], 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dbg_mem_master.md
# dbg_mem_master

Debug-side bus master that drives the CPU-under-test's memory debug port: address, write data, per-memory write enables and the load clock `clk_ld`. It reads back data memory, instruction memory or register file words. It turns single or burst read/write commands from the serial debug unit into correctly sequenced address/data/enable/`clk_ld` waveforms. Read results return to the serial side on a valid/ready stream.

## Interface
Parameters
- `SETTLE`, 1: cycles `addr` is held stable before read data is sampled (min 1).
- `LEN_W`, 16: width of the burst length field.

Ports. One clock `clk`. Reset `rstn` is asynchronous, active-low.
- `clk`  in  1  system clock
- `rstn`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when both high; equals (state==IDLE)
- `cmd_write`  in  1  1 = write burst, 0 = read burst
- `cmd_sel`  in  2  0 = DM, 1 = IM, 2 = RF, 3 = illegal
- `cmd_addr`  in  32  first word address
- `cmd_len`  in  LEN_W  word count, must be ≥1
- `wr_valid` / `wr_ready`  in/out  1/1  write-data stream handshake
- `wr_data`  in  32  write word
- `rd_valid` / `rd_ready`  out/in  1/1  read-data stream handshake
- `rd_data`  out  32  read word
- `busy`  out  1  state != IDLE
- `err`  out  1  one-cycle pulse on rejected command
- `addr`  out  32  memory address to CPU
- `din`  out  32  write data to CPU
- `we_dm`, `we_im`  out  1  write enables to CPU
- `clk_ld`  out  1  load clock to CPU memories
- `dout_dm`, `dout_im`, `dout_rf`  in  32  asynchronous read data from CPU

## Operation
- All CPU-side outputs (`addr`, `din`, `we_*`, `clk_ld`), plus `rd_data`, `rd_valid` and `err`, are registered. `cmd_ready`, `wr_ready` and `busy` decode from state.
- Reset values: `addr`=0, `din`=0, `we_dm`=`we_im`=0, `clk_ld`=0, `rd_valid`=0, `rd_data`=0, `err`=0, state IDLE. While in IDLE, `cmd_ready`=1 and `busy`=0.
- States: IDLE, RD_SETTLE, RD_OUT, WR_WAIT, WR_CLK, WR_HOLD.
- IDLE, on accepted command:
  - Reject if `cmd_len`==0, or `cmd_sel`==3, or (`cmd_write` and `cmd_sel`==2). A rejected command pulses `err` for 1 cycle, stays in IDLE, and leaves the CPU-side outputs unchanged.
  - Otherwise latch sel, latch remaining=`cmd_len`, load `addr`←`cmd_addr`. Go to RD_SETTLE (read) or WR_WAIT (write).
- RD_SETTLE: count SETTLE cycles. On the last cycle, capture the selected `dout_*` into `rd_data`, set `rd_valid`=1, go to RD_OUT.
- RD_OUT: hold `rd_data`/`rd_valid` until `rd_ready`. On the handshake, clear `rd_valid`, then:
  - if remaining==1, go to IDLE;
  - else `addr`+1, remaining−1, go to RD_SETTLE.
- WR_WAIT: `wr_ready`=1. On `wr_valid`, `din`←`wr_data` and the selected `we_*`←1, go to WR_CLK.
- WR_CLK: `clk_ld`←1 for exactly one cycle, go to WR_HOLD.
- WR_HOLD: `clk_ld`←0. Keep `we_*`, `addr`, `din` stable this cycle. On exit, `we_*`←0, then:
  - if remaining==1, go to IDLE;
  - else `addr`+1, remaining−1, go to WR_WAIT.
- Address arithmetic: +1 per word, modulo 2^32. No range check; the CPU side decodes the low bits, so wrap-around is intended.
- `rd_data` keeps its last value after `rd_valid` falls.
- Asynchronous reset mid-operation: the burst is abandoned and all outputs take their reset values immediately; `clk_ld` and `we_*` drop without completing.

## Timing
- Read: command accepted at edge E0, `addr` valid after E0, `rd_valid` high after edge E0+SETTLE. Minimum per word is SETTLE+1 cycles with `rd_ready` held high.
- Write: word accepted at edge W0.
  - After W0: `din` and `we_*` high.
  - After W1: `clk_ld` high.
  - After W2: `clk_ld` low.
  - After W3: `we_*` low and `addr` advances.
  - So `din`/`addr`/`we` have ≥1 cycle setup and ≥1 cycle hold around the `clk_ld` rise. Minimum is 4 cycles per word.
- `cmd_valid` is ignored while busy. `wr_valid` is ignored outside WR_WAIT.
- `err` and command acceptance never coincide with a memory access.

## Test plan
- DM read, `cmd_addr`=5, len 1, `dout_dm`=0xDEADBEEF when `addr`==5:
  - `rd_valid` rises SETTLE edges after accept with `rd_data`=0xDEADBEEF, then `busy` falls.
- IM burst read, addr 0x3FE, len 4, `rd_ready` low for 3 cycles on word 2:
  - `addr` sequence is 0x3FE, 0x3FF, 0x400, 0x401;
  - `rd_data` is held steady during the stall;
  - exactly 4 handshakes occur.
- DM write, 2 words 0x11, 0x22 at addr 0x10:
  - each word gives one `clk_ld` pulse;
  - `we_dm` high from 1 cycle before to 1 cycle after each pulse;
  - `we_im` stays 0;
  - `addr` is 0x10 then 0x11.
- Rejects: write to RF, `cmd_sel`=3, and len 0 each give a single 1-cycle `err` pulse, with no `we_*`/`clk_ld` activity and `busy` staying 0.
- Assert `rstn` low in the cycle after `clk_ld` rises:
  - `clk_ld`, `we_*`, `addr` go to 0 immediately;
  - after release, `cmd_ready`=1 and a new read completes normally.
- RF read, addr 3, with `wr_valid` toggling throughout: `wr_ready` stays 0 and `rd_data` equals `dout_rf`.
